// File: rtl/buffet_write_arbiter_if.sv
// Bundle of request and storage-write signals between buffet control,
// the write arbiter and the storage array.
interface buffet_write_arbiter_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 8,
    parameter int PUSH_FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(PUSH_FIFO_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] push_data_i;
    logic [ADDR_WIDTH-1:0] push_idx_i;
    logic                  push_valid_i;
    logic                  push_ready_o;
    logic [DATA_WIDTH-1:0] update_data_i;
    logic [ADDR_WIDTH-1:0] update_idx_i;
    logic                  update_valid_i;
    logic                  update_ready_o;
    logic                  wr_en_o;
    logic [ADDR_WIDTH-1:0] wr_idx_o;
    logic [DATA_WIDTH-1:0] wr_data_o;
    logic                  update_retire_o;
    logic [ADDR_WIDTH-1:0] update_retire_idx_o;
    logic [CNT_W-1:0]      push_count_o;

    // Arbiter side: consumes requests, produces storage writes.
    modport slave (
        input  push_data_i, push_idx_i, push_valid_i,
        input  update_data_i, update_idx_i, update_valid_i,
        output push_ready_o, update_ready_o,
        output wr_en_o, wr_idx_o, wr_data_o,
        output update_retire_o, update_retire_idx_o, push_count_o
    );

    // Control side: issues requests, observes writes and retires.
    modport master (
        output push_data_i, push_idx_i, push_valid_i,
        output update_data_i, update_idx_i, update_valid_i,
        input  push_ready_o, update_ready_o,
        input  wr_en_o, wr_idx_o, wr_data_o,
        input  update_retire_o, update_retire_idx_o, push_count_o
    );
endinterface

// File: rtl/buffet_write_arbiter.sv
// Buffet storage write-port arbiter: pushes are queued in a small FIFO,
// updates sit in a one-entry holding register and win by static priority,
// and a starvation counter forces a push grant after STARVE_LIMIT
// consecutive update wins while a push waits.
module buffet_write_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 8,
    parameter int PUSH_FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                   clk,
    input  logic                   reset_i,
    buffet_write_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(PUSH_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(PUSH_FIFO_DEPTH);
    localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

    typedef enum logic {PRIO = 1'b0, FORCE = 1'b1} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] fifo_idx  [PUSH_FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [PUSH_FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  hold_v;
    logic [ADDR_WIDTH-1:0] hold_idx;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [STV_W-1:0]      starve_cnt;
    logic [STV_W-1:0]      starve_nxt;

    logic                  push_ready;
    logic                  update_ready;
    logic                  push_acc;
    logic                  upd_acc;
    logic                  fifo_ne;
    logic                  grant_upd;
    logic                  grant_push;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  retire;
    logic [ADDR_WIDTH-1:0] retire_idx;

    // Grants are decided purely from registered state so the write stage
    // never sees a combinational path from the request inputs.
    assign fifo_ne      = (count != '0);
    assign grant_upd    = hold_v & ~((state == FORCE) & fifo_ne);
    assign grant_push   = fifo_ne & ~grant_upd;
    assign push_ready   = (count < DEPTH_C);
    assign update_ready = ~hold_v | grant_upd;
    assign push_acc     = bus.push_valid_i & push_ready;
    assign upd_acc      = bus.update_valid_i & update_ready;

    assign bus.push_ready_o        = push_ready;
    assign bus.update_ready_o      = update_ready;
    assign bus.push_count_o        = count;
    assign bus.wr_en_o             = wr_en;
    assign bus.wr_idx_o            = wr_idx;
    assign bus.wr_data_o           = wr_data;
    assign bus.update_retire_o     = retire;
    assign bus.update_retire_idx_o = retire_idx;

    // Starvation count: grows on each update win while a push waits, saturates.
    always_comb begin
        starve_nxt = starve_cnt;
        if (!fifo_ne || grant_push) begin
            starve_nxt = '0;
        end else if (grant_upd && (starve_cnt != LIMIT_C)) begin
            starve_nxt = starve_cnt + 1'b1;
        end
    end

    // Queue pointers, occupancy, hold flag and the PRIO/FORCE machine.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            hold_v     <= 1'b0;
            starve_cnt <= '0;
            state      <= PRIO;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (grant_push) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push_acc) - CNT_W'(grant_push);
            if (upd_acc) begin
                hold_v <= 1'b1;
            end else if (grant_upd) begin
                hold_v <= 1'b0;
            end
            starve_cnt <= starve_nxt;
            case (state)
                // Switch in the same edge the limit is reached so exactly
                // STARVE_LIMIT update writes precede the forced push.
                PRIO:    if (starve_nxt == LIMIT_C) state <= FORCE;
                FORCE:   if (grant_push || !fifo_ne) state <= PRIO;
                default: state <= PRIO;
            endcase
        end
    end

    // Payload storage for queued pushes and the held update (no reset needed).
    always_ff @(posedge clk) begin
        if (push_acc) begin
            fifo_idx[wr_ptr]  <= bus.push_idx_i;
            fifo_data[wr_ptr] <= bus.push_data_i;
        end
        if (upd_acc) begin
            hold_idx  <= bus.update_idx_i;
            hold_data <= bus.update_data_i;
        end
    end

    // Registered write port; index/data keep their last value when idle.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            wr_en      <= 1'b0;
            wr_idx     <= '0;
            wr_data    <= '0;
            retire     <= 1'b0;
            retire_idx <= '0;
        end else begin
            wr_en  <= grant_upd | grant_push;
            retire <= grant_upd;
            if (grant_upd) begin
                wr_idx     <= hold_idx;
                wr_data    <= hold_data;
                retire_idx <= hold_idx;
            end else if (grant_push) begin
                wr_idx  <= fifo_idx[rd_ptr];
                wr_data <= fifo_data[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_buffet_write_arbiter.sv
// Directed bench for buffet_write_arbiter: per-edge tables of expected
// writes (kind, index) and queue occupancy for each scenario.
module tb_buffet_write_arbiter;
    logic clk = 1'b0;
    logic reset_i = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Expected per-edge behaviour: kind 0 idle, 1 push write, 2 update write.
    int e_kind [64];
    int e_idx  [64];
    int e_cnt  [64];
    int n_exp  = 0;

    always #5 clk = ~clk;

    buffet_write_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .PUSH_FIFO_DEPTH(4)) bus ();

    buffet_write_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .PUSH_FIFO_DEPTH(4), .STARVE_LIMIT(4)
    ) dut (
        .clk    (clk),
        .reset_i(reset_i),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pdata(input logic [7:0] idx);
        return {24'hA5C3E1, idx};
    endfunction

    function automatic logic [31:0] udata(input logic [7:0] idx);
        return {24'h3C5A96, idx};
    endfunction

    task automatic ex(input int kind, input int idx, input int cnt);
        e_kind[n_exp] = kind;
        e_idx[n_exp]  = idx;
        e_cnt[n_exp]  = cnt;
        n_exp++;
    endtask

    task automatic idle_inputs();
        bus.push_valid_i   = 1'b0;
        bus.push_idx_i     = '0;
        bus.push_data_i    = '0;
        bus.update_valid_i = 1'b0;
        bus.update_idx_i   = '0;
        bus.update_data_i  = '0;
    endtask

    // Drives push_n pushes back to back (held until accepted) and an update
    // on every edge whose bit is set in upd_mask, checking the table per edge.
    task automatic run_seq(input int tid, input int push_n, input int push_base,
                           input logic [31:0] upd_mask, input int upd_base);
        int   pi;
        int   ui;
        logic pr;
        logic ur;
        logic [7:0] pidx;
        logic [7:0] uidx;
        logic [7:0] eidx;
        pi = 0;
        ui = 0;
        for (int k = 0; k < n_exp; k++) begin
            pidx = 8'(push_base + pi);
            uidx = 8'(upd_base + ui);
            bus.push_valid_i   = (pi < push_n);
            bus.push_idx_i     = pidx;
            bus.push_data_i    = pdata(pidx);
            bus.update_valid_i = upd_mask[k];
            bus.update_idx_i   = uidx;
            bus.update_data_i  = udata(uidx);
            pr = bus.push_ready_o;
            ur = bus.update_ready_o;
            @(posedge clk);
            #1;
            if (bus.push_valid_i && pr) pi++;
            if (bus.update_valid_i && ur) ui++;
            eidx = 8'(e_idx[k]);
            check($sformatf("t%0d.e%0d.wr_en", tid, k + 1), bus.wr_en_o, e_kind[k] != 0);
            check($sformatf("t%0d.e%0d.retire", tid, k + 1), bus.update_retire_o, e_kind[k] == 2);
            if (e_kind[k] != 0) begin
                check($sformatf("t%0d.e%0d.wr_idx", tid, k + 1), bus.wr_idx_o, eidx);
                check($sformatf("t%0d.e%0d.wr_data", tid, k + 1), bus.wr_data_o,
                      (e_kind[k] == 2) ? udata(eidx) : pdata(eidx));
            end
            if (e_kind[k] == 2) begin
                check($sformatf("t%0d.e%0d.retire_idx", tid, k + 1), bus.update_retire_idx_o, eidx);
            end
            check($sformatf("t%0d.e%0d.count", tid, k + 1), bus.push_count_o, e_cnt[k]);
            check($sformatf("t%0d.e%0d.push_ready", tid, k + 1), bus.push_ready_o, e_cnt[k] < 4);
        end
        idle_inputs();
        n_exp = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        #2 reset_i = 1'b1;
        #1;
        check("reset.wr_en", bus.wr_en_o, 1'b0);
        check("reset.retire", bus.update_retire_o, 1'b0);
        check("reset.count", bus.push_count_o, 0);
        check("reset.push_ready", bus.push_ready_o, 1'b1);
        check("reset.update_ready", bus.update_ready_o, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #3 reset_i = 1'b0;
        @(posedge clk);
        #1;

        // 1: push only, three entries written in order, no retire.
        ex(0, 0, 1); ex(1, 0, 1); ex(1, 1, 1); ex(1, 2, 0); ex(0, 0, 0);
        run_seq(1, 3, 'h00, 32'h0, 'h00);

        // 2: update arriving with a push is written first, push next cycle.
        ex(0, 0, 1); ex(2, 'h10, 1); ex(1, 'h03, 0); ex(0, 0, 0);
        run_seq(2, 1, 'h03, 32'h1, 'h10);

        // 3: starvation, 4 update writes then the waiting push, then updates.
        ex(0, 0, 1); ex(2, 'h20, 1); ex(2, 'h21, 1); ex(2, 'h22, 1); ex(2, 'h23, 1);
        ex(1, 'h05, 0); ex(2, 'h24, 0); ex(2, 'h25, 0); ex(2, 'h26, 0); ex(0, 0, 0);
        run_seq(3, 1, 'h05, 32'h0FF, 'h20);

        // 4: queue fills during an update stream; 5th push after forced drain.
        ex(0, 0, 1); ex(2, 'h30, 2); ex(2, 'h31, 3); ex(2, 'h32, 4); ex(2, 'h33, 4);
        ex(1, 'h40, 3); ex(2, 'h34, 4); ex(2, 'h35, 4); ex(1, 'h41, 3); ex(1, 'h42, 2);
        ex(1, 'h43, 1); ex(1, 'h44, 0); ex(0, 0, 0);
        run_seq(4, 5, 'h40, 32'h07F, 'h30);

        // 5: ten pushes through the 4-deep queue with two sporadic updates.
        ex(0, 0, 1); ex(1, 'h50, 1); ex(1, 'h51, 1); ex(2, 'h60, 2); ex(1, 'h52, 2);
        ex(1, 'h53, 2); ex(1, 'h54, 2); ex(2, 'h61, 3); ex(1, 'h55, 3); ex(1, 'h56, 3);
        ex(1, 'h57, 2); ex(1, 'h58, 1); ex(1, 'h59, 0); ex(0, 0, 0);
        run_seq(5, 10, 'h50, 32'h044, 'h60);

        // 6: three pushes queued plus a held update, then reset mid-cycle.
        ex(0, 0, 1); ex(2, 'h80, 2); ex(2, 'h81, 3);
        run_seq(6, 3, 'h70, 32'h007, 'h80);
        #2 reset_i = 1'b1;
        #1;
        check("t6.rst.wr_en", bus.wr_en_o, 1'b0);
        check("t6.rst.retire", bus.update_retire_o, 1'b0);
        check("t6.rst.count", bus.push_count_o, 0);
        check("t6.rst.push_ready", bus.push_ready_o, 1'b1);
        check("t6.rst.update_ready", bus.update_ready_o, 1'b1);
        @(posedge clk);
        #3 reset_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("t6.post%0d.wr_en", k), bus.wr_en_o, 1'b0);
            check($sformatf("t6.post%0d.count", k), bus.push_count_o, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
